dpll_loop_dco: RTL

- Loop-filter and digitally controlled oscillator (DCO) half of the DPLL.
- Consumes the XOR phase-detector error and produces the oscillator signal fed back into the phase detector's oscillator input.
- A K-counter (random-walk loop filter) turns sustained phase error into carry/borrow pulses. Each pulse advances or retards a phase accumulator whose MSB is the oscillator output.
- A windowed lock detector reports when carries and borrows balance.

---
 rtl/dpll_loop_dco.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dpll_loop_dco.sv
// -----------------------------------------------------------------------------
// dpll_loop_dco
//
// Loop-filter and DCO half of an all-digital PLL. The XOR phase-detector
// error is synchronised into the sysClock domain and drives a random-walk
// K-counter. Sustained error makes the K-counter overflow (carry) or
// underflow (borrow). Each one-cycle pulse nudges the phase accumulator
// increment up or down by STEP. The accumulator MSB is the oscillator
// output. A windowed lock detector compares carries and borrows over
// 2^LOCK_WIDTH enabled cycles.
//
// Ports:
//   sysClock     in   system clock, all state on the rising edge
//   resetN       in   asynchronous active-low reset (deassertion is
//                     assumed to be synchronised upstream)
//   enable       in   loop enable; low freezes the K-counter and
//                     clears the lock detector
//   phaseError   in   XOR phase-detector output, asynchronous to sysClock
//   oscOutput    out  DCO output (phase accumulator MSB)
//   carryPulse   out  one-cycle pulse after a K-counter up-overflow
//   borrowPulse  out  one-cycle pulse after a K-counter down-underflow
//   locked       out  lock indicator, updated only at window ends
// -----------------------------------------------------------------------------
module dpll_loop_dco #(
    parameter int K_WIDTH     = 4,
    parameter int ACC_WIDTH   = 8,
    parameter int NOMINAL_INC = 16,
    parameter int STEP        = 4,
    parameter int LOCK_WIDTH  = 6,
    parameter int LOCK_TOL    = 1
) (
    input  logic sysClock,
    input  logic resetN,
    input  logic enable,
    input  logic phaseError,
    output logic oscOutput,
    output logic carryPulse,
    output logic borrowPulse,
    output logic locked
);

    // Net pulse counter is signed and one bit wider than the window counter.
    // A window can never hold more pulses than it has cycles, so it cannot
    // overflow.
    localparam int NW = LOCK_WIDTH + 1;

    localparam logic [K_WIDTH-1:0]    K_MID    = {1'b1, {(K_WIDTH-1){1'b0}}};
    localparam logic [K_WIDTH-1:0]    K_MAX    = {K_WIDTH{1'b1}};
    localparam logic [K_WIDTH-1:0]    K_ZERO   = {K_WIDTH{1'b0}};
    localparam logic [K_WIDTH-1:0]    K_ONE    = K_WIDTH'(1);
    localparam logic [ACC_WIDTH-1:0]  NOM_V    = ACC_WIDTH'(NOMINAL_INC);
    localparam logic [ACC_WIDTH-1:0]  STEP_V   = ACC_WIDTH'(STEP);
    localparam logic [ACC_WIDTH-1:0]  ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam logic [LOCK_WIDTH-1:0] WIN_LAST = {LOCK_WIDTH{1'b1}};
    localparam logic [LOCK_WIDTH-1:0] WIN_ONE  = LOCK_WIDTH'(1);
    localparam logic [LOCK_WIDTH-1:0] WIN_ZERO = {LOCK_WIDTH{1'b0}};
    localparam logic signed [NW-1:0]  NET_ONE  = NW'(1);
    localparam logic signed [NW-1:0]  NET_ZERO = {NW{1'b0}};
    localparam logic [NW-1:0]         TOL_V    = NW'(LOCK_TOL);

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous phase error.
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;   // errSync

    always_ff @(posedge sysClock or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= phaseError;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // K-counter (random-walk filter) with registered carry/borrow pulses.
    // Up and down are mutually exclusive each cycle, so the two pulses can
    // never be high together.
    // -------------------------------------------------------------------------
    logic [K_WIDTH-1:0] k_q;
    logic [K_WIDTH-1:0] k_d;
    logic               carry_q;
    logic               carry_d;
    logic               borrow_q;
    logic               borrow_d;

    always_comb begin
        k_d      = k_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (enable) begin
            if (sync2_q) begin
                // Modulo wrap from K_MAX to 0 is the natural adder overflow.
                k_d     = k_q + K_ONE;
                carry_d = (k_q == K_MAX);
            end else begin
                k_d      = k_q - K_ONE;
                borrow_d = (k_q == K_ZERO);
            end
        end
    end

    always_ff @(posedge sysClock or negedge resetN) begin
        if (!resetN) begin
            k_q      <= K_MID;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            k_q      <= k_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Phase accumulator (DCO). Runs regardless of enable. A pulse shapes
    // the increment in the same cycle it is visible on the output port.
    // -------------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = acc_q + NOM_V
                + (carry_q  ? STEP_V : ACC_ZERO)
                - (borrow_q ? STEP_V : ACC_ZERO);
    end

    always_ff @(posedge sysClock or negedge resetN) begin
        if (!resetN) begin
            acc_q <= ACC_ZERO;
        end else begin
            acc_q <= acc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Lock detector. The pulse visible in the window's last cycle is folded
    // into the decision (net_step), not carried into the next window.
    // -------------------------------------------------------------------------
    logic [LOCK_WIDTH-1:0] win_q;
    logic [LOCK_WIDTH-1:0] win_d;
    logic signed [NW-1:0]  net_q;
    logic signed [NW-1:0]  net_d;
    logic signed [NW-1:0]  net_step;
    logic [NW-1:0]         net_abs;
    logic                  locked_q;
    logic                  locked_d;

    always_comb begin
        net_step = net_q;
        if (carry_q) begin
            net_step = net_q + NET_ONE;
        end else if (borrow_q) begin
            net_step = net_q - NET_ONE;
        end
    end

    always_comb begin
        net_abs = net_step[NW-1] ? $unsigned(NET_ZERO - net_step) : $unsigned(net_step);
    end

    always_comb begin
        win_d    = win_q;
        net_d    = net_q;
        locked_d = locked_q;
        if (!enable) begin
            win_d    = WIN_ZERO;
            net_d    = NET_ZERO;
            locked_d = 1'b0;
        end else if (win_q == WIN_LAST) begin
            win_d    = WIN_ZERO;
            net_d    = NET_ZERO;
            locked_d = (net_abs <= TOL_V);
        end else begin
            win_d = win_q + WIN_ONE;
            net_d = net_step;
        end
    end

    always_ff @(posedge sysClock or negedge resetN) begin
        if (!resetN) begin
            win_q    <= WIN_ZERO;
            net_q    <= NET_ZERO;
            locked_q <= 1'b0;
        end else begin
            win_q    <= win_d;
            net_q    <= net_d;
            locked_q <= locked_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all straight from flops.
    // -------------------------------------------------------------------------
    assign oscOutput   = acc_q[ACC_WIDTH-1];
    assign carryPulse  = carry_q;
    assign borrowPulse = borrow_q;
    assign locked      = locked_q;

endmodule
